// File: rtl/seq_gen_if.sv
// seq_gen_if: control, table-write and pattern-output bundle for seq_gen.
// master drives the controls; slave is the generator side.
interface seq_gen_if #(
  parameter int unsigned WIDTH = 3,
  parameter int unsigned DEPTH = 8
);
  localparam int unsigned AW = $clog2(DEPTH);

  logic             en;
  logic             start;
  logic             dir;
  logic             oneshot;
  logic             len_we;
  logic [AW:0]      len_in;
  logic             wr_en;
  logic [AW-1:0]    wr_addr;
  logic [WIDTH-1:0] wr_data;
  logic [WIDTH-1:0] seq_out;
  logic [AW-1:0]    idx;
  logic             busy;
  logic             wrap;
  logic             done;

  modport master (
    output en, start, dir, oneshot, len_we, len_in, wr_en, wr_addr, wr_data,
    input  seq_out, idx, busy, wrap, done
  );

  modport slave (
    input  en, start, dir, oneshot, len_we, len_in, wr_en, wr_addr, wr_data,
    output seq_out, idx, busy, wrap, done
  );
endinterface

// File: rtl/seq_gen.sv
// seq_gen: steps an index through a writable pattern table with run-time length and up/down/loop control.
// Define SEQ_GEN_ONESHOT_EN to enable one-shot runs (DONE state and the done level); otherwise every run loops.
module seq_gen #(
  parameter int unsigned WIDTH = 3,
  parameter int unsigned DEPTH = 8
) (
  input  logic     clk,
  input  logic     rst,
  seq_gen_if.slave bus
);
  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned LW = AW + 1;
  localparam logic [LW-1:0] LEN_MAX = LW'(DEPTH);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] tbl [DEPTH];
  logic [LW-1:0]    len;
  logic [AW-1:0]    idx_q;
  logic             dir_q;
  logic             busy_q;
  logic             wrap_q;
`ifdef SEQ_GEN_ONESHOT_EN
  logic             os_q;
  logic             done_q;
`endif

  logic             len_acc_c;
  logic [LW-1:0]    len_wr_c;
  logic [LW-1:0]    len_eff_c;
  logic [AW-1:0]    last_c;
  logic             at_end_c;
  logic             wr_ok_c;

  // Length writes are only honoured outside RUN; a same-cycle start sees the new length.
  always_comb begin
    len_acc_c = bus.len_we && (state != RUN);
    len_wr_c  = ((bus.len_in == '0) || (bus.len_in > LEN_MAX)) ? LEN_MAX : bus.len_in;
    len_eff_c = len_acc_c ? len_wr_c : len;
    last_c    = AW'(len - LW'(1));
    at_end_c  = dir_q ? (idx_q == '0) : (idx_q == last_c);
    wr_ok_c   = ({1'b0, bus.wr_addr} < LEN_MAX);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      idx_q  <= '0;
      len    <= LEN_MAX;
      dir_q  <= 1'b0;
      busy_q <= 1'b0;
      wrap_q <= 1'b0;
`ifdef SEQ_GEN_ONESHOT_EN
      os_q   <= 1'b0;
      done_q <= 1'b0;
`endif
      for (int unsigned i = 0; i < DEPTH; i++) begin
        tbl[i] <= WIDTH'(i);
      end
    end else begin
      wrap_q <= 1'b0;

      if (bus.wr_en && wr_ok_c) begin
        tbl[bus.wr_addr] <= bus.wr_data;
      end

      if (len_acc_c) begin
        len   <= len_wr_c;
        idx_q <= '0;
      end

      // Start wins over stepping and restarts from any state.
      if (bus.start) begin
        state  <= RUN;
        busy_q <= 1'b1;
        dir_q  <= bus.dir;
        idx_q  <= bus.dir ? AW'(len_eff_c - LW'(1)) : '0;
`ifdef SEQ_GEN_ONESHOT_EN
        os_q   <= bus.oneshot;
        done_q <= 1'b0;
`endif
      end else if ((state == RUN) && bus.en) begin
        if (at_end_c) begin
`ifdef SEQ_GEN_ONESHOT_EN
          if (os_q) begin
            state  <= DONE;
            busy_q <= 1'b0;
            done_q <= 1'b1;
          end else
`endif
          begin
            idx_q  <= dir_q ? last_c : '0;
            wrap_q <= 1'b1;
          end
        end else begin
          idx_q <= dir_q ? (idx_q - AW'(1)) : (idx_q + AW'(1));
        end
      end
    end
  end

  assign bus.seq_out = tbl[idx_q];
  assign bus.idx     = idx_q;
  assign bus.busy    = busy_q;
  assign bus.wrap    = wrap_q;
`ifdef SEQ_GEN_ONESHOT_EN
  assign bus.done    = done_q;
`else
  logic unused_oneshot;
  assign unused_oneshot = bus.oneshot;
  assign bus.done       = 1'b0;
`endif

endmodule

// File: tb/tb_seq_gen.sv
// tb_seq_gen: directed and random stimulus for seq_gen, checked against a step-count reference model.
// The model derives the index from the number of enabled steps since start, modulo the length.
module tb_seq_gen;
  logic clk = 1'b0;
  logic rst = 1'b0;
  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;

  always #5 clk = ~clk;

  seq_gen_if #(.WIDTH(3), .DEPTH(8)) bus ();

  seq_gen #(.WIDTH(3), .DEPTH(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct packed {
    logic [2:0] idx;
    logic [2:0] seq;
    logic       busy;
    logic       wrap;
    logic       done;
  } exp_t;

  // Reference model state: a run is described by its step count, not by an index register.
  logic [2:0] m_tbl [8];
  int         m_len;
  int         m_steps;
  bit         m_active;
  bit         m_dir;
  bit         m_os;
  bit         m_sticky;
  bit         m_wrap;

  function automatic void model_reset();
    for (int i = 0; i < 8; i++) m_tbl[i] = 3'(i);
    m_len = 8; m_steps = 0; m_active = 0; m_dir = 0; m_os = 0; m_sticky = 0; m_wrap = 0;
  endfunction

  function automatic exp_t model_exp();
    exp_t e;
    int   r;
    e.wrap = m_wrap;
    if (!m_active) begin
      e.idx = 3'd0; e.busy = 1'b0; e.done = m_sticky;
    end else if (m_os && (m_steps >= m_len)) begin
      e.idx = m_dir ? 3'd0 : 3'(m_len - 1); e.busy = 1'b0; e.done = 1'b1;
    end else begin
      r = m_steps % m_len;
      e.idx = m_dir ? 3'(m_len - 1 - r) : 3'(r); e.busy = 1'b1; e.done = 1'b0;
    end
    e.seq = m_tbl[e.idx];
    return e;
  endfunction

  // Drive one cycle of inputs, advance the model at the edge, settle for sampling.
  task automatic step(input bit e, input bit s, input bit d, input bit o, input bit lw, input int li,
                      input bit we, input int wa, input int wd);
    exp_t pre;
    pre = model_exp();
    bus.en = e; bus.start = s; bus.dir = d; bus.oneshot = o; bus.len_we = lw;
    bus.len_in = 4'(li); bus.wr_en = we; bus.wr_addr = 3'(wa); bus.wr_data = 3'(wd);
    @(posedge clk);
    if (rst) begin
      model_reset();
    end else begin
      if (we && (wa < 8)) m_tbl[wa] = 3'(wd);
      if (lw && !pre.busy) begin
        m_len = ((li == 0) || (li > 8)) ? 8 : li;
        m_sticky = pre.done;
        m_active = 0;
      end
      m_wrap = 0;
      if (s) begin
        m_active = 1; m_steps = 0; m_dir = d; m_sticky = 0;
`ifdef SEQ_GEN_ONESHOT_EN
        m_os = o;
`else
        m_os = 0;
`endif
      end else if (m_active && e && pre.busy) begin
        m_steps++;
        if (!m_os && (m_steps % m_len == 0)) m_wrap = 1;
      end
    end
    #1;
    cyc++;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step(0, 0, 0, 0, 0, 0, 0, 0, 0);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    exp_t got;
    do_reset();
    got = {bus.idx, bus.seq_out, bus.busy, bus.wrap, bus.done};
    checks++;
    if (got !== 9'b0) begin
      failures++;
      $display("FAIL reset_state got{idx,seq,busy,wrap,done}=%b want=%b", got, 9'b0);
    end
    checks++;
    if (got !== model_exp()) begin
      failures++;
      $display("FAIL reset_model got=%b want=%b", got, model_exp());
    end
  endtask

  task automatic test_loop_up();
    exp_t got;
    for (int k = 0; k < 10; k++) begin
      if (k == 0) step(1, 1, 0, 0, 0, 0, 0, 0, 0);
      else        step(1, 0, 0, 0, 0, 0, 0, 0, 0);
      got = {bus.idx, bus.seq_out, bus.busy, bus.wrap, bus.done};
      checks++;
      if ((got.seq !== 3'(k % 8)) || (got.wrap !== (k == 8)) || (got.busy !== 1'b1)) begin
        failures++;
        $display("FAIL loop_up k=%0d got seq=%0d wrap=%b busy=%b want seq=%0d wrap=%b busy=1",
                 k, got.seq, got.wrap, got.busy, k % 8, (k == 8));
      end
    end
  endtask

  task automatic test_table_write();
    exp_t got;
    int   pat [8];
    pat = '{0, 3, 2, 5, 1, 6, 4, 7};
    for (int i = 0; i < 8; i++) step(0, 0, 0, 0, 0, 0, 1, i, pat[i]);
    for (int k = 0; k < 17; k++) begin
      step(1, (k == 0), 0, 0, 0, 0, 0, 0, 0);
      got = {bus.idx, bus.seq_out, bus.busy, bus.wrap, bus.done};
      checks++;
      if ((got.seq !== 3'(pat[k % 8])) || (got.wrap !== ((k > 0) && (k % 8 == 0))) ||
          (got !== model_exp())) begin
        failures++;
        $display("FAIL table_pattern k=%0d got=%b want seq=%0d model=%b", k, got, pat[k % 8], model_exp());
      end
    end
  endtask

  task automatic test_len_down();
    exp_t got;
    int   dn [6];
    dn = '{4, 3, 2, 1, 0, 4};
    do_reset();
    for (int k = 0; k < 6; k++) begin
      step(1, (k == 0), 1, 0, (k == 0), 5, 0, 0, 0);
      got = {bus.idx, bus.seq_out, bus.busy, bus.wrap, bus.done};
      checks++;
      if ((got.idx !== 3'(dn[k])) || (got.wrap !== (k == 5)) || (got !== model_exp())) begin
        failures++;
        $display("FAIL len5_down k=%0d got=%b want idx=%0d wrap=%b", k, got, dn[k], (k == 5));
      end
    end
    do_reset();
    step(0, 0, 0, 0, 1, 0, 0, 0, 0);
    step(0, 1, 1, 0, 0, 0, 0, 0, 0);
    checks++;
    if ((bus.idx !== 3'd7) || (bus.busy !== 1'b1)) begin
      failures++;
      $display("FAIL len0_as_depth got idx=%0d busy=%b want idx=7 busy=1", bus.idx, bus.busy);
    end
  endtask

  task automatic test_oneshot();
    exp_t got;
    exp_t want;
    do_reset();
    step(0, 0, 0, 0, 1, 4, 0, 0, 0);
    for (int k = 0; k < 7; k++) begin
      step(1, (k == 0), 0, 1, 0, 0, 0, 0, 0);
      got = {bus.idx, bus.seq_out, bus.busy, bus.wrap, bus.done};
`ifdef SEQ_GEN_ONESHOT_EN
      want.idx = (k < 3) ? 3'(k) : 3'd3; want.busy = (k < 4); want.wrap = 1'b0; want.done = (k >= 4);
`else
      want.idx = 3'(k % 4); want.busy = 1'b1; want.wrap = (k == 4); want.done = 1'b0;
`endif
      want.seq = want.idx;
      checks++;
      if (got !== want) begin
        failures++;
        $display("FAIL oneshot k=%0d got{idx,seq,busy,wrap,done}=%b want=%b", k, got, want);
      end
    end
    step(0, 0, 0, 0, 1, 6, 0, 0, 0);
    got = {bus.idx, bus.seq_out, bus.busy, bus.wrap, bus.done};
    checks++;
    if (got !== model_exp()) begin
      failures++;
      $display("FAIL oneshot_len_write got=%b want=%b", got, model_exp());
    end
    step(1, 1, 0, 1, 0, 0, 0, 0, 0);
    checks++;
    if ((bus.idx !== 3'd0) || (bus.done !== 1'b0) || (bus.busy !== 1'b1)) begin
      failures++;
      $display("FAIL oneshot_restart got idx=%0d done=%b busy=%b want idx=0 done=0 busy=1",
               bus.idx, bus.done, bus.busy);
    end
  endtask

  task automatic test_en_toggle();
    exp_t got;
    int   ens [5];
    int   ids [5];
    ens = '{1, 0, 0, 1, 1};
    ids = '{1, 1, 1, 2, 3};
    do_reset();
    step(1, 1, 0, 0, 0, 0, 0, 0, 0);
    for (int k = 0; k < 5; k++) begin
      step(ens[k] != 0, 0, 0, 0, 0, 0, 0, 0, 0);
      checks++;
      if ((bus.idx !== 3'(ids[k])) || (bus.wrap !== 1'b0)) begin
        failures++;
        $display("FAIL en_toggle k=%0d got idx=%0d wrap=%b want idx=%0d wrap=0", k, bus.idx, bus.wrap, ids[k]);
      end
    end
    step(1, 1, 0, 0, 0, 0, 0, 0, 0);
    checks++;
    if (bus.idx !== 3'd0) begin
      failures++;
      $display("FAIL midrun_start got idx=%0d want 0", bus.idx);
    end
    step(1, 0, 0, 0, 1, 3, 0, 0, 0);
    for (int k = 0; k < 7; k++) step(1, 0, 0, 0, 0, 0, 0, 0, 0);
    got = {bus.idx, bus.seq_out, bus.busy, bus.wrap, bus.done};
    checks++;
    if ((got.idx !== 3'd0) || (got.wrap !== 1'b1) || (got !== model_exp())) begin
      failures++;
      $display("FAIL len_we_in_run got=%b want idx=0 wrap=1 model=%b", got, model_exp());
    end
  endtask

  task automatic test_reset_midrun();
    exp_t got;
    step(0, 0, 0, 0, 0, 0, 1, 2, 6);
    step(0, 0, 0, 0, 0, 0, 1, 5, 1);
    step(1, 0, 0, 0, 0, 0, 0, 0, 0);
    do_reset();
    got = {bus.idx, bus.seq_out, bus.busy, bus.wrap, bus.done};
    checks++;
    if (got !== 9'b0) begin
      failures++;
      $display("FAIL reset_midrun got{idx,seq,busy,wrap,done}=%b want=%b", got, 9'b0);
    end
    for (int k = 0; k < 8; k++) begin
      step(1, (k == 0), 0, 0, 0, 0, 0, 0, 0);
      checks++;
      if (bus.seq_out !== 3'(k)) begin
        failures++;
        $display("FAIL reset_table k=%0d got seq=%0d want %0d", k, bus.seq_out, k);
      end
    end
  endtask

  task automatic test_random();
    exp_t got;
    for (int n = 0; n < 600; n++) begin
      if ($urandom_range(0, 99) < 2) begin
        do_reset();
      end else begin
        step($urandom_range(0, 99) < 70, $urandom_range(0, 99) < 8, 1'($urandom_range(0, 1)),
             1'($urandom_range(0, 1)), $urandom_range(0, 99) < 10, $urandom_range(0, 15),
             $urandom_range(0, 99) < 20, $urandom_range(0, 7), $urandom_range(0, 7));
      end
      got = {bus.idx, bus.seq_out, bus.busy, bus.wrap, bus.done};
      checks++;
      if (got !== model_exp()) begin
        failures++;
        $display("FAIL random cyc=%0d got{idx,seq,busy,wrap,done}=%b want=%b", cyc, got, model_exp());
      end
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_loop_up();
    test_table_write();
    test_len_down();
    test_oneshot();
    test_en_toggle();
    test_reset_midrun();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog timeout at cyc=%0d", cyc);
    $fatal(1, "timeout");
  end
endmodule

// File: doc/seq_gen.md
# seq_gen

Parametrised, table-driven sequence generator: the general form of the fixed 3-bit, 8-state hard-coded sequence FSM. It steps an index through a writable table of `DEPTH` entries of `WIDTH` bits and outputs the selected entry. It supports:
- run-time length
- up/down stepping
- clock-enable gating
- looping and one-shot modes

It drives display/LED pattern outputs and test stimulus in the lab designs.

## Interface
Parameters:
- `WIDTH`, 3: bits per table entry / output.
- `DEPTH`, 8: table entries, ≥2. Index width `AW = $clog2(DEPTH)`.

Ports:
- `clk`  in  1  clock; all logic on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `en`  in  1  step enable; index advances only in RUN with `en`=1.
- `start`  in  1  begin or restart a run.
- `dir`  in  1  0 = up, 1 = down; sampled on `start`.
- `oneshot`  in  1  0 = loop, 1 = stop after one pass; sampled on `start`.
- `len_we`  in  1  length write strobe.
- `len_in`  in  AW+1  active length, 1..DEPTH.
- `wr_en`  in  1  table write strobe.
- `wr_addr`  in  AW  table write address.
- `wr_data`  in  WIDTH  table write data.
- `seq_out`  out  WIDTH  `table[idx]`.
- `idx`  out  AW  current index.
- `busy`  out  1  high in RUN.
- `wrap`  out  1  one-cycle pulse on a loop wrap.
- `done`  out  1  one-shot pass complete; level.

## Operation
- Reset values:
  - state = IDLE
  - `idx` = 0
  - length = DEPTH
  - latched dir = 0, latched oneshot = 0
  - `busy` = `wrap` = `done` = 0
  - `table[i]` = i mod 2^WIDTH
  - `seq_out` = 0
- FSM states: IDLE, RUN, DONE.
  - IDLE → RUN on `start`.
  - RUN → RUN on `start` (restart).
  - RUN → DONE at the end of a one-shot pass.
  - DONE → RUN on `start`.
- On `start` (any state):
  - latch `dir` and `oneshot`.
  - `idx` ← 0 if up, length−1 if down.
  - clear `done`.
- RUN with `en`=1:
  - up: `idx`+1; at `idx` = length−1, wrap to 0.
  - down: `idx`−1; at `idx` = 0, wrap to length−1.
  - `en`=0: `idx` holds; no pulses.
- At the wrap point:
  - loop mode: wrap, `wrap`=1 for one cycle.
  - one-shot: no wrap; `idx` stays on the last entry, go DONE, `done`=1, no `wrap` pulse.
- Length write:
  - `len_we` is accepted only in IDLE or DONE and ignored in RUN.
  - `len_in` of 0 or >DEPTH is stored as DEPTH.
  - An accepted write also sets `idx` ← 0.
  - If `len_we` and `start` occur in the same cycle, the start uses the new length.
- Table write:
  - `wr_en` is accepted in any state.
  - `table[wr_addr]` ← `wr_data`.
  - `wr_addr` ≥ DEPTH is ignored.
- `seq_out` is a combinational read of `table[idx]` from registered `idx` and table.
- `rst` mid-run returns every register to its reset value, table included.

## Timing
- `start` at edge n → `idx` = start index and `busy`=1 after edge n; first step at the first later edge with `en`=1.
- Step latency: one clock per enabled cycle; `seq_out` follows `idx` in the same cycle.
- `wrap` is high for exactly the cycle after the wrapping edge, while `idx` shows the wrapped value.
- `done` rises after the edge that would have wrapped, in the same cycle `busy` falls.
- Table write at edge n is visible on `seq_out` after edge n when `wr_addr` = `idx`.
- Write to the same address as a step in the same cycle: `seq_out` shows the new data at the new `idx` if the addresses match.

## Configuration
- Macro: `SEQ_GEN_ONESHOT_EN`.
- Defined: one-shot mode, the DONE state and the `done` output behave as above.
- Undefined:
  - `oneshot` is ignored; every run loops.
  - DONE is unreachable.
  - `done` is tied to 0.
  - Ports are unchanged.

## Test plan
- Reset, then `en`=1, `start`, up, loop, defaults → `seq_out` 0,1,…,7,0; `wrap` pulses once at the 7→0 step; `busy`=1.
- Write table 0,3,2,5,1,6,4,7, then up, loop → `seq_out` 0,3,2,5,1,6,4,7,0,… with `wrap` on each return to 0.
- `len_in`=5, down, loop → `idx` 4,3,2,1,0,4; `wrap` on the 0→4 step; `len_in`=0 → length 8.
- One-shot up, length 4 (requires `SEQ_GEN_ONESHOT_EN`) → `idx` 0,1,2,3 then holds at 3; `done`=1, `busy`=0, no `wrap`; `start` restarts at 0 with `done`=0.
- Toggle `en` 1,0,0,1 during RUN → `idx` holds on the 0 cycles. Assert `start` mid-run → `idx`=0 next cycle. Assert `len_we` during RUN → length unchanged.
- `rst` mid-run after a table write → `idx`=0, IDLE, `table[i]`=i, all flags 0.
